mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (DPI pmem_read/pmem_write) between IFU fetch and LSU load/store.
//  Holds one transaction in flight. LSU has priority, with a starvation guard for IFU.
//  Sequences mem_ren/mem_wen and holds address and width stable until read data is captured.
//  Returns responses over valid/ready. Sits between the IFU/LSU and the memory module.
// PARAMETERS
//  RD_LAT      1  cycles from mem_ren-high cycle to mem_rdata valid (>=1)
//  STREAK_MAX  4  consecutive LSU grants allowed while IFU waits (>=1)
// PORTS
//  clk             in   1             clock, all state on posedge
//  rst             in   1             asynchronous, active-high reset
//  ifu_req_valid   in   1             fetch request
//  ifu_req_ready   out  1             fetch request accepted
//  ifu_addr        in   `RegWidth     fetch address, width fixed `Wdt32
//  ifu_resp_valid  out  1             fetch data valid
//  ifu_resp_ready  in   1             IFU takes data
//  ifu_rdata       out  `ImmWidth     fetched word, zero-extended
//  lsu_req_valid   in   1             load/store request
//  lsu_req_ready   out  1             load/store accepted
//  lsu_addr        in   `RegWidth     byte address
//  lsu_wen         in   1             1 = store, 0 = load
//  lsu_wdata       in   `RegWidth     store data, low-aligned
//  lsu_wdt_op      in   `WdtTypeCnt   access width (`Wdt8/16/32/64)
//  lsu_resp_valid  out  1             load data valid / store done
//  lsu_resp_ready  in   1             LSU takes response
//  lsu_rdata       out  `ImmWidth     load data, zero-extended; 0 for stores
//  mem_raddr       out  `RegWidth     to memory
//  mem_waddr       out  `AddrWidth    to memory, low bits of latched address
//  mem_wdata       out  `RegWidth     to memory
//  mem_ren         out  1             to memory
//  mem_wen         out  1             to memory
//  wdt_op          out  `WdtTypeCnt   to memory
//  mem_rdata       in   `ImmWidth     from memory, already width/offset extracted
//  misalign        out  1             pulse: latched access not naturally aligned
// BEHAVIOUR
//  Reset: FSM=IDLE, streak=0, all valid/ready/ren/wen/misalign=0, latched addr/data/op/rdata=0.
//  FSM: IDLE -> ACCESS -> WAIT (RD_LAT cycles) -> RESP -> IDLE.
//  IDLE:
//   - Arbitrate combinationally. Grant LSU if lsu_req_valid, except when ifu_req_valid and streak==STREAK_MAX; then grant IFU.
//   - Assert the winner's req_ready only. Latch addr, wen, wdata, op (IFU: op=`Wdt32, wen=0) and owner. Go to ACCESS.
//   - streak: +1 on an LSU grant while IFU valid; cleared on any IFU grant or when IFU is not valid. Saturates at STREAK_MAX.
//  ACCESS (exactly 1 cycle): mem_ren = ~wen, mem_wen = wen. Address/data/op come from latched regs.
//   - misalign=1 this cycle if addr[0] set for Wdt16, addr[1:0]!=0 for Wdt32, or addr[2:0]!=0 for Wdt64.
//   - A misaligned access still proceeds.
//  WAIT: down-counter loaded with RD_LAT. mem_ren/mem_wen=0.
//   - mem_raddr and wdt_op stay driven from latched regs, because the memory extraction mux is combinational on them.
//   - On the last WAIT cycle, capture mem_rdata (reads) or 0 (writes) into the resp register, then go to RESP.
//  RESP: owner's resp_valid=1, held with stable rdata until resp_ready. On handshake go to IDLE; no new grant in that cycle.
//  Latency: request accepted at cycle 0 -> resp_valid at cycle 2+RD_LAT. Back-to-back throughput is 1 per 3+RD_LAT cycles.
//  Non-owner resp_valid=0 always. req_ready=0 outside IDLE. Requesters must hold req fields stable until ready.
//  Simultaneous requests with streak<STREAK_MAX: LSU wins and IFU stays pending (ready=0).
//  Reset mid-transaction: return to IDLE immediately and drop the in-flight response.
//   - A write already strobed in ACCESS is not undone.
//  mem_wen is high for exactly one cycle per store (memory commits on negedge); never together with mem_ren.
// STRUCTURE
//  Shared package/defines: state enum {IDLE,ACCESS,WAIT,RESP}, owner enum {OWN_IFU,OWN_LSU}, existing `Wdt* codes.
//  One sub-module: mem_align_check (addr[2:0], wdt_op -> misalign), combinational, reusable by LSU.
//  Latency counter width is $clog2(RD_LAT+1).
// TESTING
//  1. LSU load Wdt64 @0x80000008, mem_rdata=0x1122334455667788 -> lsu_resp_valid at cycle 3, lsu_rdata=0x1122334455667788.
//  2. LSU store Wdt8 @0x80000003 wdata=0xAB -> exactly one mem_wen cycle, mem_waddr=..03, wdt_op=Wdt8, lsu_rdata=0.
//  3. Both requesting continuously -> grants LSU x4 then IFU x1, repeating; streak never exceeds 4.
//  4. Wdt32 load @0x80000002 -> misalign=1 for one cycle in ACCESS; the response is still returned.
//  5. Hold lsu_resp_ready=0 for 5 cycles -> resp_valid/rdata stable, no grant issued; completes on ready.
//  6. Assert rst during WAIT -> all outputs 0 at once; after release, a new IFU fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, access-width codes and FSM/owner enums
package mem_port_arbiter_pkg;
   localparam int REG_W  = 64;
   localparam int IMM_W  = 64;
   localparam int ADDR_W = 32;
   localparam int WDT_W  = 2;
   localparam logic [WDT_W-1:0] WDT8  = 2'd0;
   localparam logic [WDT_W-1:0] WDT16 = 2'd1;
   localparam logic [WDT_W-1:0] WDT32 = 2'd2;
   localparam logic [WDT_W-1:0] WDT64 = 2'd3;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
endpackage

// File: rtl/mem_align_check.sv
// mem_align_check: flags accesses that are not naturally aligned for their width
module mem_align_check
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0]       addr,
   input  logic [WDT_W-1:0] wdt_op,
   output logic             misalign
);
   always_comb
      misalign = (wdt_op == WDT16) ? addr[0] :
                 (wdt_op == WDT32) ? |addr[1:0] :
                 (wdt_op == WDT64) ? |addr : 1'b0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU fetch and LSU load/store
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [REG_W-1:0]  ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [IMM_W-1:0]  ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [REG_W-1:0]  lsu_addr,
   input  logic              lsu_wen,
   input  logic [REG_W-1:0]  lsu_wdata,
   input  logic [WDT_W-1:0]  lsu_wdt_op,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [IMM_W-1:0]  lsu_rdata,
   output logic [REG_W-1:0]  mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [REG_W-1:0]  mem_wdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [WDT_W-1:0]  wdt_op,
   input  logic [IMM_W-1:0]  mem_rdata,
   output logic              misalign
);
   localparam int CNT_W = $clog2(RD_LAT + 1);
   localparam int STK_W = $clog2(STREAK_MAX + 1);

   state_e             state_q, state_d;
   owner_e             owner_q, owner_d;
   logic [REG_W-1:0]   addr_q, addr_d;
   logic               wen_q, wen_d;
   logic [REG_W-1:0]   wdata_q, wdata_d;
   logic [WDT_W-1:0]   op_q, op_d;
   logic [IMM_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STK_W-1:0]   streak_q, streak_d;
   logic               grant_lsu, grant_ifu, streak_full, align_mis, resp;

   mem_align_check u_align (
      .addr     (addr_q[2:0]),
      .wdt_op   (op_q),
      .misalign (align_mis)
   );

   always_comb begin
      streak_full = streak_q == STK_W'(STREAK_MAX);
      grant_lsu   = state_q == IDLE && lsu_req_valid && !(ifu_req_valid && streak_full);
      grant_ifu   = state_q == IDLE && ifu_req_valid && !grant_lsu;
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      op_d        = op_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE:
            if (grant_lsu || grant_ifu) begin
               state_d = ACCESS;
               owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
               addr_d  = grant_lsu ? lsu_addr : ifu_addr;
               wen_d   = grant_lsu && lsu_wen;
               wdata_d = grant_lsu ? lsu_wdata : '0;
               op_d    = grant_lsu ? lsu_wdt_op : WDT32;
            end
         ACCESS: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LAT);
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               rdata_d = wen_q ? '0 : mem_rdata;
            end
         end
         RESP: if (owner_q == OWN_LSU ? lsu_resp_ready : ifu_resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // streak only counts LSU wins that actually kept a waiting IFU out
      streak_d = (!ifu_req_valid || grant_ifu) ? '0 :
                 (grant_lsu && !streak_full) ? streak_q + STK_W'(1) : streak_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IFU;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         op_q     <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         op_q     <= op_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
      end

   assign resp           = state_q == RESP;
   assign ifu_req_ready  = grant_ifu;
   assign lsu_req_ready  = grant_lsu;
   assign ifu_resp_valid = resp && owner_q == OWN_IFU;
   assign lsu_resp_valid = resp && owner_q == OWN_LSU;
   assign ifu_rdata      = owner_q == OWN_IFU ? rdata_q : '0;
   assign lsu_rdata      = owner_q == OWN_LSU ? rdata_q : '0;
   // address and width stay driven after ACCESS: the memory extraction mux reads them combinationally
   assign mem_raddr      = addr_q;
   assign mem_waddr      = addr_q[ADDR_W-1:0];
   assign mem_wdata      = wdata_q;
   assign wdt_op         = op_q;
   assign mem_ren        = state_q == ACCESS && !wen_q;
   assign mem_wen        = state_q == ACCESS && wen_q;
   assign misalign       = state_q == ACCESS && align_mis;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_port_arbiter;
   logic        clk = 0, rst = 1;
   logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1;
   logic [63:0] ifu_addr = 0, ifu_rdata;
   logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 1;
   logic [63:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
   logic [1:0]  lsu_wdt_op = 0, wdt_op;
   logic [63:0] mem_raddr, mem_wdata, mem_rdata;
   logic [31:0] mem_waddr;
   logic        mem_ren, mem_wen, misalign;
   logic        rd_ok = 0, force_en = 0;
   logic [63:0] force_val = 0;
   logic [31:0] salt = 32'h1357_9BDF;
   int          total = 0, bad = 0, cyc = 0;
   int          g_who[$], g_cyc[$], r_who[$], r_cyc[$];
   logic [63:0] r_data[$];
   int          wen_cnt = 0, both_cnt = 0, mis_cnt = 0, mis_cyc = 0;
   logic [31:0] wen_addr = 0;
   logic [63:0] wen_data = 0;
   logic [1:0]  wen_op = 0;

   mem_port_arbiter #(.RD_LAT(1), .STREAK_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wdt_op(lsu_wdt_op),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op), .mem_rdata(mem_rdata),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] memfn(input logic [63:0] a, input logic [31:0] s);
      return {a[31:0] ^ s, ~a[31:0] + s};
   endfunction

   function automatic logic [63:0] ext(input logic [63:0] d, input logic [1:0] op);
      return op == 0 ? {56'b0, d[7:0]} : op == 1 ? {48'b0, d[15:0]} : op == 2 ? {32'b0, d[31:0]} : d;
   endfunction

   // memory data is only meaningful in the cycle RD_LAT after the read strobe
   always @(posedge clk) rd_ok <= mem_ren;
   always @(posedge clk) cyc <= cyc + 1;
   assign mem_rdata = !rd_ok ? 64'hDEAD_BEEF_DEAD_BEEF : force_en ? force_val : ext(memfn(mem_raddr, salt), wdt_op);

   always @(negedge clk)
      if (!rst) begin
         if (ifu_req_valid && ifu_req_ready) begin g_who.push_back(0); g_cyc.push_back(cyc); end
         if (lsu_req_valid && lsu_req_ready) begin g_who.push_back(1); g_cyc.push_back(cyc); end
         if (ifu_resp_valid && ifu_resp_ready) begin r_who.push_back(0); r_cyc.push_back(cyc); r_data.push_back(ifu_rdata); end
         if (lsu_resp_valid && lsu_resp_ready) begin r_who.push_back(1); r_cyc.push_back(cyc); r_data.push_back(lsu_rdata); end
         if (mem_wen) begin
            wen_cnt  <= wen_cnt + 1;
            wen_addr <= mem_waddr;
            wen_data <= mem_wdata;
            wen_op   <= wdt_op;
         end
         if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
         if (misalign) begin mis_cnt <= mis_cnt + 1; mis_cyc <= cyc; end
      end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input bit is_lsu, input logic [63:0] a, input logic w, input logic [63:0] d,
                      input logic [1:0] op, output bit ok);
      bit hit;
      if (is_lsu) begin
         lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wdt_op = op; lsu_req_valid = 1;
      end else begin
         ifu_addr = a; ifu_req_valid = 1;
      end
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         hit = is_lsu ? lsu_req_ready : ifu_req_ready;
      end
      step;
      if (is_lsu) lsu_req_valid = 0; else ifu_req_valid = 0;
      ok = hit;
      hit = 0;
      for (int i = 0; i < 20 && !hit && ok; i++) begin
         @(negedge clk);
         hit = is_lsu ? (lsu_resp_valid && lsu_resp_ready) : (ifu_resp_valid && ifu_resp_ready);
      end
      ok = ok && hit;
      step;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0) begin
         bad++; $display("FAIL reset_handshake: got %b want 0000", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
      end
      total++;
      if ({mem_ren, mem_wen, misalign} !== 3'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 000", {mem_ren, mem_wen, misalign});
      end
      total++;
      if ({mem_raddr, mem_wdata, wdt_op} !== '0) begin
         bad++; $display("FAIL reset_latched: raddr %h wdata %h op %0d want 0", mem_raddr, mem_wdata, wdt_op);
      end
      total++;
      if ({ifu_rdata, lsu_rdata} !== '0) begin
         bad++; $display("FAIL reset_rdata: got %h %h want 0", ifu_rdata, lsu_rdata);
      end
      rst = 0;
      step;
   endtask

   task automatic test_load;
      bit ok;
      force_en = 1; force_val = 64'h1122334455667788;
      txn(1, 64'h80000008, 0, 0, 2'd3, ok);
      force_en = 0;
      total++;
      if (!ok) begin bad++; $display("FAIL load_timeout: got no response want one"); end
      total++;
      if (r_cyc[$] - g_cyc[$] !== 3) begin bad++; $display("FAIL load_latency: got %0d want 3", r_cyc[$] - g_cyc[$]); end
      total++;
      if (r_data[$] !== 64'h1122334455667788 || r_who[$] !== 1) begin
         bad++; $display("FAIL load_data: got %h owner %0d want 1122334455667788 owner 1", r_data[$], r_who[$]);
      end
   endtask

   task automatic test_store;
      bit ok;
      int w0 = wen_cnt;
      txn(1, 64'h80000003, 1, 64'hAB, 2'd0, ok);
      total++;
      if (!ok || wen_cnt - w0 !== 1) begin bad++; $display("FAIL store_wen_count: got %0d ok %0d want 1", wen_cnt - w0, ok); end
      total++;
      if (wen_addr !== 32'h80000003 || wen_op !== 2'd0 || wen_data !== 64'hAB) begin
         bad++; $display("FAIL store_fields: addr %h op %0d data %h want 80000003 0 ab", wen_addr, wen_op, wen_data);
      end
      total++;
      if (r_data[$] !== 64'h0 || both_cnt !== 0) begin
         bad++; $display("FAIL store_resp: rdata %h ren+wen %0d want 0 0", r_data[$], both_cnt);
      end
   endtask

   task automatic test_misalign;
      bit ok, exp;
      logic [63:0] a;
      logic [1:0] op;
      int m0;
      for (int i = 0; i < 8; i++) begin
         a  = i == 0 ? 64'h80000002 : 64'h80000000 | 64'($urandom_range(0, 7));
         op = i == 0 ? 2'd2 : 2'($urandom_range(0, 3));
         exp = (a % (64'd1 << op)) != 0;
         m0 = mis_cnt;
         salt = $urandom;
         txn(1, a, 0, 0, op, ok);
         total++;
         if (!ok || mis_cnt - m0 !== int'(exp)) begin
            bad++; $display("FAIL misalign_flag: addr %h op %0d got %0d want %0d", a, op, mis_cnt - m0, exp);
         end
         total++;
         if (r_data[$] !== ext(memfn(a, salt), op)) begin
            bad++; $display("FAIL misalign_data: addr %h got %h want %h", a, r_data[$], ext(memfn(a, salt), op));
         end
         if (exp) begin
            total++;
            if (mis_cyc !== g_cyc[$] + 1) begin bad++; $display("FAIL misalign_cycle: got %0d want %0d", mis_cyc, g_cyc[$] + 1); end
         end
      end
   endtask

   task automatic test_fairness;
      int gb = g_who.size();
      int rb = r_who.size();
      ifu_addr = 64'h80000100; lsu_addr = 64'h80000200; lsu_wen = 0; lsu_wdt_op = 2'd3;
      ifu_req_valid = 1; lsu_req_valid = 1;
      for (int i = 0; i < 300 && g_who.size() < gb + 10; i++) @(negedge clk);
      step;
      ifu_req_valid = 0; lsu_req_valid = 0;
      for (int i = 0; i < 50 && r_who.size() < rb + 10; i++) @(negedge clk);
      step;
      total++;
      if (g_who.size() - gb !== 10 || r_who.size() - rb !== 10) begin
         bad++; $display("FAIL fair_count: grants %0d resps %0d want 10 10", g_who.size() - gb, r_who.size() - rb);
      end else
         for (int i = 0; i < 10; i++) begin
            total++;
            if (g_who[gb+i] !== (i % 5 == 4 ? 0 : 1)) begin
               bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, g_who[gb+i], i % 5 == 4 ? 0 : 1);
            end
            if (i > 0) begin
               total++;
               if (g_cyc[gb+i] - g_cyc[gb+i-1] !== 4) begin
                  bad++; $display("FAIL fair_spacing[%0d]: got %0d want 4", i, g_cyc[gb+i] - g_cyc[gb+i-1]);
               end
            end
         end
   endtask

   task automatic test_backpressure;
      bit hit = 0;
      logic [63:0] held;
      salt = $urandom;
      lsu_resp_ready = 0; ifu_resp_ready = 1;
      lsu_addr = 64'h80000040; lsu_wen = 0; lsu_wdt_op = 2'd3; ifu_addr = 64'h80000080;
      ifu_req_valid = 1; lsu_req_valid = 1;
      for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = lsu_req_ready; end
      total++;
      if (!hit || ifu_req_ready !== 0) begin bad++; $display("FAIL bp_grant: lsu %0d ifu %0d want 1 0", hit, ifu_req_ready); end
      step;
      lsu_req_valid = 0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = lsu_resp_valid; end
      held = lsu_rdata;
      total++;
      if (!hit || held !== memfn(64'h80000040, salt)) begin
         bad++; $display("FAIL bp_data: got %h want %h", held, memfn(64'h80000040, salt));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (lsu_resp_valid !== 1 || lsu_rdata !== held || ifu_req_ready !== 0 || ifu_resp_valid !== 0) begin
            bad++; $display("FAIL bp_hold[%0d]: valid %0d rdata %h ifu_ready %0d want 1 %h 0", i, lsu_resp_valid, lsu_rdata, ifu_req_ready, held);
         end
      end
      step;
      lsu_resp_ready = 1;
      @(negedge clk);
      total++;
      if (lsu_resp_valid !== 1 || ifu_req_ready !== 0) begin
         bad++; $display("FAIL bp_release: valid %0d ifu_ready %0d want 1 0", lsu_resp_valid, ifu_req_ready);
      end
      step;
      @(negedge clk);
      total++;
      if (ifu_req_ready !== 1) begin bad++; $display("FAIL bp_next_grant: got %0d want 1", ifu_req_ready); end
      step;
      ifu_req_valid = 0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = ifu_resp_valid; end
      total++;
      if (!hit || ifu_rdata !== ext(memfn(64'h80000080, salt), 2)) begin
         bad++; $display("FAIL bp_ifu_data: got %h want %h", ifu_rdata, ext(memfn(64'h80000080, salt), 2));
      end
      step;
   endtask

   task automatic test_reset_mid;
      bit hit = 0, ok;
      int n0;
      lsu_addr = 64'h80000010; lsu_wen = 0; lsu_wdt_op = 2'd3; lsu_req_valid = 1;
      for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = lsu_req_ready; end
      step;
      lsu_req_valid = 0;
      n0 = r_who.size();
      step;
      rst = 1;
      #1;
      total++;
      if ({lsu_resp_valid, ifu_resp_valid, mem_ren, mem_wen, misalign} !== 5'b0 || mem_raddr !== 0 || wdt_op !== 0 || lsu_rdata !== 0) begin
         bad++; $display("FAIL rstmid_outputs: valid %0d ren %0d raddr %h op %0d want all 0", lsu_resp_valid, mem_ren, mem_raddr, wdt_op);
      end
      step;
      rst = 0;
      repeat (4) step;
      total++;
      if (r_who.size() !== n0) begin bad++; $display("FAIL rstmid_dropped: got %0d resps want 0", r_who.size() - n0); end
      salt = $urandom;
      txn(0, 64'h80000020, 0, 0, 2'd2, ok);
      total++;
      if (!ok || r_who[$] !== 0 || r_data[$] !== ext(memfn(64'h80000020, salt), 2) || r_cyc[$] - g_cyc[$] !== 3) begin
         bad++; $display("FAIL rstmid_fetch: ok %0d data %h want %h", ok, r_data[$], ext(memfn(64'h80000020, salt), 2));
      end
   endtask

   task automatic test_random;
      bit busy = 0, own = 0, gi = 0, gl = 0, ev;
      int gc = 0, stk = 0;
      logic [63:0] ed = 0, rd;
      salt = $urandom;
      for (int c = 0; c < 400; c++) begin
         if (!ifu_req_valid || gi) begin
            ifu_req_valid = $urandom_range(0, 2) != 0;
            ifu_addr = 64'h80000000 | 64'($urandom_range(0, 63) * 4);
         end
         if (!lsu_req_valid || gl) begin
            lsu_req_valid = $urandom_range(0, 1) != 0;
            lsu_addr = 64'h80000000 | 64'($urandom_range(0, 255));
            lsu_wen = $urandom_range(0, 1) != 0;
            lsu_wdata = {$urandom, $urandom};
            lsu_wdt_op = 2'($urandom_range(0, 3));
         end
         lsu_resp_ready = $urandom_range(0, 3) != 0;
         ifu_resp_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         gi = ifu_req_valid && ifu_req_ready;
         gl = lsu_req_valid && lsu_req_ready;
         total++;
         if ((gi && gl) || (busy && (gi || gl)) || (!busy && (ifu_req_valid || lsu_req_valid) && !(gi || gl))) begin
            bad++; $display("FAIL rand_grant: cyc %0d busy %0d gi %0d gl %0d", cyc, busy, gi, gl);
         end
         if (!busy && ifu_req_valid && lsu_req_valid) begin
            total++;
            if (gl !== (stk < 4)) begin bad++; $display("FAIL rand_arb: cyc %0d lsu_win %0d want %0d", cyc, gl, stk < 4); end
         end
         ev = busy && cyc - gc >= 3;
         total++;
         if ({ifu_resp_valid, lsu_resp_valid, mem_ren && mem_wen} !== {ev && !own, ev && own, 1'b0}) begin
            bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, {ifu_resp_valid, lsu_resp_valid, mem_ren && mem_wen}, {ev && !own, ev && own, 1'b0});
         end
         if (ev) begin
            rd = own ? lsu_rdata : ifu_rdata;
            total++;
            if (rd !== ed) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", cyc, rd, ed); end
            if (own ? lsu_resp_ready : ifu_resp_ready) busy = 0;
         end
         stk = (!ifu_req_valid || gi) ? 0 : gl ? (stk < 4 ? stk + 1 : 4) : stk;
         if (gi || gl) begin
            busy = 1; own = gl; gc = cyc;
            ed = gl ? (lsu_wen ? 64'h0 : ext(memfn(lsu_addr, salt), lsu_wdt_op)) : ext(memfn(ifu_addr, salt), 2);
         end
         step;
      end
      ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 1; lsu_resp_ready = 1;
      repeat (8) step;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_load;
      test_store;
      test_misalign;
      test_fairness;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
